// File: rtl/clockgen_prog.sv
// Programmable slow-clock / tick generator: period and high time are loaded at
// runtime and take effect only at a period boundary, so mclk never glitches.
module clockgen_prog #(
    parameter int WIDTH        = 26,
    parameter int DEFAULT_DIV  = 50000000,
    parameter int DEFAULT_HIGH = 25000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_clear,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             mclk,
    output logic             tick,
    output logic             cfg_pending,
    output logic             load_ack,
    output logic             cfg_err
);

    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] div_act, high_act, div_nxt, high_nxt;
    logic [WIDTH-1:0] div_pend, high_pend;
    logic             load_ok, wrap, apply, mclk_nxt;

    assign load_ok = load && (div_in >= WIDTH'(2)) && (high_in != '0) && (high_in < div_in);
    assign wrap    = enable && (cnt == div_act - WIDTH'(1));
    assign apply   = cfg_pending && (sync_clear || wrap);

    // mclk is evaluated against the config that will be live next cycle,
    // so the first cycle of a freshly applied period already uses it.
    always_comb begin
        div_nxt  = apply ? div_pend  : div_act;
        high_nxt = apply ? high_pend : high_act;
        cnt_nxt  = cnt;
        mclk_nxt = mclk;
        if (sync_clear) begin
            cnt_nxt  = '0;
            mclk_nxt = 1'b0;
        end else if (enable) begin
            cnt_nxt  = wrap ? '0 : cnt + WIDTH'(1);
            mclk_nxt = (cnt_nxt >= div_nxt - high_nxt);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            div_act     <= WIDTH'(DEFAULT_DIV);
            high_act    <= WIDTH'(DEFAULT_HIGH);
            div_pend    <= '0;
            high_pend   <= '0;
            cfg_pending <= 1'b0;
            mclk        <= 1'b0;
            tick        <= 1'b0;
            load_ack    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            div_act  <= div_nxt;
            high_act <= high_nxt;
            mclk     <= mclk_nxt;
            tick     <= sync_clear || wrap;
            load_ack <= apply;
            cfg_err  <= load && !load_ok;
            // A new load always lands in pending, even when an older one applies now.
            if (load_ok) begin
                div_pend    <= div_in;
                high_pend   <= high_in;
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clockgen_prog.sv
// Directed bench for clockgen_prog with DIV=10/HIGH=5 defaults; cnt is tracked
// by hand in the step comments.
module tb_clockgen_prog;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset, enable, sync_clear, load;
    logic [W-1:0] div_in, high_in;
    logic         mclk, tick, cfg_pending, load_ack, cfg_err;

    int checks = 0;
    int errors = 0;

    clockgen_prog #(.WIDTH(W), .DEFAULT_DIV(10), .DEFAULT_HIGH(5)) dut (
        .clock(clock), .reset(reset), .enable(enable), .sync_clear(sync_clear),
        .load(load), .div_in(div_in), .high_in(high_in),
        .mclk(mclk), .tick(tick), .cfg_pending(cfg_pending),
        .load_ack(load_ack), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic m, input logic t,
                           input logic p, input logic a, input logic e);
        chk({tag, "_mclk"}, mclk, m);
        chk({tag, "_tick"}, tick, t);
        chk({tag, "_pend"}, cfg_pending, p);
        chk({tag, "_ack"}, load_ack, a);
        chk({tag, "_err"}, cfg_err, e);
    endtask

    task automatic do_load(input logic [W-1:0] d, input logic [W-1:0] h);
        load = 1'b1; div_in = d; high_in = h;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; sync_clear = 1'b0; load = 1'b0;
        div_in = '0; high_in = '0;
        step(2);
        chk_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // default 10/5: state s counts edges since release, cnt = s % 10
        for (int s = 0; s < 20; s++) begin
            chk("def_mclk", mclk, (s % 10) >= 5);
            chk("def_tick", tick, (s % 10 == 0) && (s > 0));
            step();
        end
        step(3);                                   // cnt=3
        do_load(4, 1); step(); load = 1'b0;        // cnt=4
        chk_all("ld_pend", 0, 0, 1, 0, 0);
        step(5);                                   // cnt=9
        chk_all("ld_cnt9", 1, 0, 1, 0, 0);
        step();                                    // new period, cfg 4/1
        chk_all("ld_apply", 0, 1, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            chk("p4_mclk", mclk, (k % 4) == 3);
            chk("p4_tick", tick, (k % 4) == 0);
            step();
        end                                        // cnt=0

        do_load(1, 1); step(); load = 1'b0;        // cnt=1
        chk_all("bad_div", 0, 0, 0, 0, 1);
        step();                                    // cnt=2
        chk("err_clear", cfg_err, 0);
        do_load(5, 0); step();                     // cnt=3
        chk_all("bad_high0", 1, 0, 0, 0, 1);
        do_load(5, 5); step(); load = 1'b0;        // cnt=0
        chk_all("bad_higheq", 0, 1, 0, 0, 1);

        do_load(10, 5); step();                    // cnt=1, pending 10/5
        do_load(1, 1); step(); load = 1'b0;        // cnt=2
        chk_all("bad_keep", 0, 0, 1, 0, 1);
        step();                                    // cnt=3
        chk("p4_still", mclk, 1);
        step();                                    // cnt=0, cfg 10/5
        chk_all("back10", 0, 1, 0, 1, 0);
        step(6);                                   // cnt=6
        enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("frz_mclk", mclk, 1);
            chk("frz_tick", tick, 0);
        end
        enable = 1'b1;
        step(3);                                   // cnt=9
        chk("resume_9", tick, 0);
        step();                                    // cnt=0
        chk("resume_wrap", tick, 1);

        do_load(6, 2); step(); load = 1'b0;        // cnt=1
        step();                                    // cnt=2
        sync_clear = 1'b1; step(); sync_clear = 1'b0;
        chk_all("sclr", 0, 1, 0, 1, 0);
        for (int k = 0; k < 12; k++) begin
            chk("p6_mclk", mclk, (k % 6) >= 4);
            chk("p6_tick", tick, (k % 6) == 0);
            step();
        end                                        // cnt=0

        do_load(8, 4); step();                     // cnt=1, pending 8/4
        do_load(10, 5); sync_clear = 1'b1;
        step(); load = 1'b0; sync_clear = 1'b0;    // 8/4 live, 10/5 pending
        chk_all("sclr_ld", 0, 1, 1, 1, 0);
        step(4);                                   // cnt=4
        chk("p8_c4", mclk, 1);
        step(3);                                   // cnt=7
        chk_all("p8_c7", 1, 0, 1, 0, 0);
        step();                                    // cnt=0, 10/5 live
        chk_all("p8_wrap", 0, 1, 0, 1, 0);
        step(4);                                   // cnt=4
        chk("p10_c4", mclk, 0);
        step();                                    // cnt=5
        chk("p10_c5", mclk, 1);

        do_load(4, 1); step(); load = 1'b0;        // cnt=6, pending
        step(2);                                   // cnt=8
        reset = 1'b1; step(); reset = 1'b0;
        chk_all("rst2", 0, 0, 0, 0, 0);
        for (int s = 0; s < 11; s++) begin
            chk("rst_mclk", mclk, (s % 10) >= 5);
            chk("rst_tick", tick, (s % 10 == 0) && (s > 0));
            chk("rst_ack", load_ack, 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
